// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
// State encoding, requester ids and the round-robin pick.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LSU   = 1'b1;

  localparam int TIMEOUT_DEF = 16;

  // Pick the next owner; on contention favour the id that did not go last.
  function automatic state_t arbitrate(
    input logic r0,
    input logic r1,
    input logic last
  );
    state_t nxt;
    nxt = IDLE;
    unique case (1'b1)
      (r0 && r1):  nxt = (last == REQ_FETCH) ? GNT1 : GNT0;
      (r0 && !r1): nxt = GNT0;
      (!r0 && r1): nxt = GNT1;
      default:     nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// 2:1 32-bit address mux feeding the shared memory port.
// Pure combinational select between the two requester addresses.
module mux_2x1 (
  input  logic [31:0] I0,
  input  logic [31:0] I1,
  input  logic        s,
  output logic [31:0] Y
);

  // Route I1 when s is set, otherwise I0.
  always_comb begin
    Y = s ? I1 : I0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the shared memory address port.
// Holds a grant per transaction; aborts on withdrawal or stall.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic        mem_ready,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic        sel,
  output logic        timeout_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             last;
  logic             last_n;
  logic             sel_n;
  logic             done0_n;
  logic             done1_n;
  logic             terr_n;

  logic             id;
  logic             own_req;

  // State, counter, owner history and registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= REQ_LSU;
      sel         <= REQ_FETCH;
      done0       <= 1'b0;
      done1       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      last        <= last_n;
      sel         <= sel_n;
      done0       <= done0_n;
      done1       <= done1_n;
      timeout_err <= terr_n;
    end
  end

  // Next state: arbitrate when idle or when a transaction ends.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    done0_n = 1'b0;
    done1_n = 1'b0;
    terr_n  = 1'b0;
    id      = (state == GNT1);
    own_req = id ? req1 : req0;

    case (state)
      IDLE: begin
        state_n = arbitrate(req0, req1, last);
      end
      GNT0, GNT1: begin
        if (mem_ready) begin
          done0_n = !id;
          done1_n = id;
          last_n  = id;
          cnt_n   = '0;
          state_n = arbitrate(req0, req1, id);
        end else if (!own_req) begin
          last_n  = id;
          cnt_n   = '0;
          state_n = arbitrate(req0, req1, id);
        end else if (cnt == CNT_LAST) begin
          terr_n  = 1'b1;
          last_n  = id;
          cnt_n   = '0;
          state_n = arbitrate(req0, req1, id);
        end else begin
          cnt_n   = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Select follows the grant; it is held while idle.
  always_comb begin
    sel_n = sel;
    unique case (1'b1)
      (state_n == GNT0): sel_n = REQ_FETCH;
      (state_n == GNT1): sel_n = REQ_LSU;
      default:           sel_n = sel;
    endcase
  end

  // Port-facing grant and valid decode.
  always_comb begin
    gnt0      = (state == GNT0);
    gnt1      = (state == GNT1);
    mem_valid = gnt0 | gnt1;
  end

  mux_2x1 u_addr_mux (
    .I0 (addr0),
    .I1 (addr1),
    .s  (sel),
    .Y  (mem_addr)
  );

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 32-bit memory address port.
- Requester 0 is instruction fetch; requester 1 is load/store.
- Grants the port round-robin, holds each grant for a full multi-cycle transaction, and drives the select of a 2:1 32-bit mux onto mem_addr.
- Aborts a transaction that stalls longer than TIMEOUT cycles.
- Sits between the fetch/LSU front ends and the memory interface.

Parameters:
- TIMEOUT, 16: maximum cycles a grant may wait for mem_ready before abort (legal range 2..255).
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req0  in  1  fetch request; held high until done0 or abort.
- addr0  in  32  fetch address; stable while gnt0 is high.
- req1  in  1  load/store request; same rules as req0.
- addr1  in  32  load/store address.
- mem_ready  in  1  memory accepts and completes the current transaction this cycle.
- gnt0  out  1  port granted to requester 0.
- gnt1  out  1  port granted to requester 1.
- done0  out  1  one-cycle pulse: requester 0 transaction completed.
- done1  out  1  one-cycle pulse: requester 1 transaction completed.
- mem_valid  out  1  transaction active on the memory port.
- mem_addr  out  32  muxed address: addr1 when sel=1, else addr0.
- sel  out  1  mux select, equal to the id of the current or last grant.
- timeout_err  out  1  one-cycle pulse: the granted transaction was aborted by timeout.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, gnt0=gnt1=0, mem_valid=0, done0=done1=0, timeout_err=0, sel=0, counter=0.
  - last_grant=1, so the first contended request goes to requester 0.
- States: IDLE, GNT0, GNT1.
- gnt0=(state==GNT0), gnt1=(state==GNT1), mem_valid=gnt0|gnt1.
- mem_addr is combinational from sel through the mux.
- Arbitration runs in IDLE and at every transaction end:
  - only reqX high -> grant X;
  - both high -> grant the id != last_grant;
  - neither -> IDLE.
- Latency:
  - A request sampled high at edge N in IDLE gives gnt/mem_valid high from edge N onward, i.e. visible in the cycle after the request.
  - sel updates on the same edge as the grant.
- In GNTx, at each edge:
  - mem_ready=1 -> doneX=1 for the next cycle, last_grant=x, counter=0, re-arbitrate. Back-to-back grant to the other requester occurs with no idle bubble; the same requester may be regranted only if the other is not requesting.
  - reqX=0 (requester withdrew) with mem_ready=0 -> abort: no done, no timeout_err, last_grant=x, counter=0, re-arbitrate.
  - counter==TIMEOUT-1 with mem_ready=0 -> abort: timeout_err=1 for one cycle, no done, last_grant=x, counter=0, re-arbitrate.
  - otherwise -> counter+1 and stay.
- Priority of simultaneous events: rst > mem_ready > withdrawal > timeout.
- mem_ready in IDLE is ignored.
- req of the non-granted requester during a grant is held pending; there is no pre-emption.
- In IDLE, sel keeps its last value and mem_valid=0.
- done and timeout_err are registered single-cycle pulses and never both high.
- Reset mid-transaction: every output returns to its reset value on that edge; no done is issued.
- Counter never exceeds TIMEOUT-1; no wrap.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'b00, GNT0=2'b01, GNT1=2'b10; 2'b11 is illegal and recovers to IDLE;
  - requester id constants REQ_FETCH=1'b0, REQ_LSU=1'b1;
  - default TIMEOUT.
- One sub-module: the existing mux_2x1 instantiated for mem_addr (Y=mem_addr, s=sel, I1=addr1, I0=addr0).
- Arbitration and counter logic stay in this block.

Test Plan:
1. Reset then single request: rst for 2 cycles; req0=1, addr0=32'h00000040; mem_ready high on the 3rd grant cycle -> gnt0 for 3 cycles, mem_addr=32'h00000040, sel=0, done0 one pulse, then IDLE.
2. Contention and round-robin: req0=req1=1 continuously, mem_ready=1 every grant cycle -> grants alternate 0,1,0,1 with no idle cycles; done0/done1 alternate; mem_addr alternates between addr0=32'h00000000 and addr1=32'h11111111.
3. Timeout: TIMEOUT=4, req1=1, mem_ready=0 -> gnt1 high for exactly 4 cycles, timeout_err one pulse, no done1; if req1 is still high the arbiter regrants 1 (req0 low).
4. Simultaneous terminal events: mem_ready=1 on the same edge the counter reaches TIMEOUT-1 -> done asserted, timeout_err stays 0.
5. Withdrawal and pending request: grant 0 active, req1 raised, req0 dropped before mem_ready -> no done0, next cycle gnt1=1 and sel=1.
6. Reset mid-transaction: rst asserted during GNT1 -> next edge gnt1=0, mem_valid=0, sel=0; after release with both requests high, requester 0 is granted first.
